density_tlc: RTL and testbench

Parametrised density-actuated traffic-light controller for an intersection of `NUM_ROADS` approaches. Each approach has a vehicle-density (demand) sensor. Green time is extended while the served road stays busy and is bounded by minimum and maximum limits. Service rotates round-robin among demanding roads through a yellow and an all-red clearance phase. It is the multi-road, timing-configurable successor to the fixed two-main/two-side controller, and drives the lamp outputs directly.

---
 rtl/density_tlc.sv | 164 ++++++++++++++++
 tb/tb_density_tlc.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/density_tlc.sv
// density_tlc: density-actuated traffic-light controller for NUM_ROADS approaches.
// Green is held while the served road stays busy, bounded by MIN_GREEN/MAX_GREEN
// whenever another road waits. Service rotates round-robin among demanding roads,
// passing through a yellow and an all-red clearance phase between greens.
module density_tlc #(
    parameter int NUM_ROADS    = 4,
    parameter int ROAD_W       = $clog2(NUM_ROADS),
    parameter int CNT_W        = 8,
    parameter int MIN_GREEN    = 4,
    parameter int MAX_GREEN    = 12,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_ROADS-1:0] demand,
    output logic [NUM_ROADS-1:0] red,
    output logic [NUM_ROADS-1:0] yellow,
    output logic [NUM_ROADS-1:0] green,
    output logic [ROAD_W-1:0]    active_road,
    output logic [1:0]           phase,
    output logic                 green_start
);

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'b00,
        PH_GREEN   = 2'b01,
        PH_YELLOW  = 2'b10
    } phase_t;

    // Last timer value of each timed phase (timer counts from 0).
    localparam logic [CNT_W-1:0] C_AR_LAST  = CNT_W'(ALL_RED_TIME - 1);
    localparam logic [CNT_W-1:0] C_Y_LAST   = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] C_MIN_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] C_MAX_LAST = CNT_W'(MAX_GREEN - 1);

    // Round-robin search: first waiting road after 'cur', wrapping modulo NUM_ROADS.
    function automatic logic [ROAD_W-1:0] f_pick_next(
        input logic [ROAD_W-1:0]    cur,
        input logic [NUM_ROADS-1:0] waiting
    );
        logic [ROAD_W-1:0] sel;
        logic [ROAD_W-1:0] cand;
        logic              found;
        int                idx;
        sel   = cur;
        found = 1'b0;
        for (int k = 1; k < NUM_ROADS; k++) begin
            idx  = (int'(cur) + k) % NUM_ROADS;
            cand = ROAD_W'(idx);
            if (!found && waiting[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    phase_t                r_phase;
    logic [ROAD_W-1:0]     r_active;
    logic [ROAD_W-1:0]     r_next;
    logic [CNT_W-1:0]      r_timer;
    logic                  r_gs;

    phase_t                w_phase_nxt;
    logic [ROAD_W-1:0]     w_active_nxt;
    logic [ROAD_W-1:0]     w_next_nxt;
    logic [CNT_W-1:0]      w_timer_nxt;
    logic [NUM_ROADS-1:0]  w_mask;
    logic [NUM_ROADS-1:0]  w_others;
    logic                  w_min_met;
    logic                  w_max_hit;
    logic                  w_gap;
    logic                  w_leave_green;

    // Demand seen by the green decision: everyone except the road being served.
    assign w_mask        = NUM_ROADS'(1) << r_active;
    assign w_others      = demand & ~w_mask;
    assign w_min_met     = (r_timer >= C_MIN_LAST);
    assign w_max_hit     = (r_timer == C_MAX_LAST);
    assign w_gap         = ~demand[r_active];
    // Gap-out and max-out collapse into one exit; no one waiting means rest in green.
    assign w_leave_green = (|w_others) && w_min_met && (w_gap || w_max_hit);

    // State register: rst wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= PH_ALL_RED;
            r_active <= '0;
            r_next   <= '0;
            r_timer  <= '0;
            r_gs     <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_active <= w_active_nxt;
            r_next   <= w_next_nxt;
            r_timer  <= w_timer_nxt;
            r_gs     <= (w_phase_nxt == PH_GREEN) && (r_phase != PH_GREEN);
        end
    end

    // Next-state logic; demand only influences the GREEN decision.
    always_comb begin
        w_phase_nxt  = r_phase;
        w_active_nxt = r_active;
        w_next_nxt   = r_next;
        unique case (r_phase)
            PH_ALL_RED: begin
                if (r_timer == C_AR_LAST) begin
                    w_phase_nxt  = PH_GREEN;
                    w_active_nxt = r_next;
                end
            end
            PH_GREEN: begin
                if (w_leave_green) begin
                    w_phase_nxt = PH_YELLOW;
                    w_next_nxt  = f_pick_next(r_active, w_others);
                end
            end
            PH_YELLOW: begin
                if (r_timer == C_Y_LAST) begin
                    w_phase_nxt = PH_ALL_RED;
                end
            end
            default: begin
                w_phase_nxt = PH_ALL_RED;
            end
        endcase

        // Timer restarts with each phase and parks at MAX_GREEN-1 while resting in green.
        if (w_phase_nxt != r_phase) begin
            w_timer_nxt = '0;
        end else if ((r_phase == PH_GREEN) && (r_timer >= C_MAX_LAST)) begin
            w_timer_nxt = C_MAX_LAST;
        end else begin
            w_timer_nxt = r_timer + CNT_W'(1);
        end
    end

    // Lamp decode from state only: one lamp lit per road at all times.
    always_comb begin
        red    = '1;
        yellow = '0;
        green  = '0;
        unique case (r_phase)
            PH_GREEN: begin
                green = w_mask;
                red   = ~w_mask;
            end
            PH_YELLOW: begin
                yellow = w_mask;
                red    = ~w_mask;
            end
            default: begin
                red = '1;
            end
        endcase
    end

    assign active_road = r_active;
    assign phase       = r_phase;
    assign green_start = r_gs;

endmodule

// File: tb/tb_density_tlc.sv
// Self-checking bench for density_tlc (default parameters): a table of hand-derived
// vectors, directed multi-cycle corner sequences and a random run, all compared
// every cycle with a behavioural model of the signal plan.
module tb_density_tlc;

    localparam int N    = 4;
    localparam int MING = 4;
    localparam int MAXG = 12;
    localparam int YT   = 3;
    localparam int ART  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] demand;
    logic [3:0] red, yellow, green;
    logic [1:0] active_road;
    logic [1:0] phase;
    logic       green_start;

    int total = 0;
    int bad   = 0;

    // Behavioural model: phase code, served road, chosen successor, cycles spent in phase.
    int m_ph   = 0;
    int m_road = 0;
    int m_next = 0;
    int m_age  = 0;

    typedef struct {
        logic       rst;
        logic [3:0] dem;
        logic [3:0] red;
        logic [3:0] yel;
        logic [3:0] grn;
        logic [1:0] ph;
        logic [1:0] act;
        logic       gs;
    } vec_t;

    vec_t tbl[15];

    density_tlc dut (
        .clk         (clk),
        .rst         (rst),
        .demand      (demand),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .active_road (active_road),
        .phase       (phase),
        .green_start (green_start)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input int road, input int waiting);
        int r;
        for (int k = 1; k < N; k++) begin
            r = (road + k) % N;
            if (((waiting >> r) & 1) == 1) return r;
        end
        return road;
    endfunction

    task automatic model_step(input logic r, input logic [3:0] dem);
        int d;
        int others;
        bit busy;
        d = int'(dem);
        if (r) begin
            m_ph = 0; m_road = 0; m_next = 0; m_age = 0;
        end else begin
            case (m_ph)
                0: if (m_age + 1 >= ART) begin
                       m_ph = 1; m_road = m_next; m_age = 0;
                   end else m_age++;
                1: begin
                       others = d & ~(1 << m_road);
                       busy   = ((d >> m_road) & 1) == 1;
                       if (others != 0 && m_age + 1 >= MING && (!busy || m_age + 1 >= MAXG)) begin
                           m_ph = 2; m_next = pick(m_road, others); m_age = 0;
                       end else m_age++;
                   end
                default: if (m_age + 1 >= YT) begin
                       m_ph = 0; m_age = 0;
                   end else m_age++;
            endcase
        end
    endtask

    task automatic model_check(input string name);
        int eg, ey, er;
        bit egs;
        bit ok;
        eg  = (m_ph == 1) ? (1 << m_road) : 0;
        ey  = (m_ph == 2) ? (1 << m_road) : 0;
        er  = 15 & ~(eg | ey);
        egs = (m_ph == 1) && (m_age == 0);
        chk(name, {15'd0, red, yellow, green, phase, active_road, green_start},
            {15'd0, 4'(er), 4'(ey), 4'(eg), 2'(m_ph), 2'(m_road), egs});
        ok = 1'b1;
        for (int i = 0; i < N; i++)
            if (int'(red[i]) + int'(yellow[i]) + int'(green[i]) != 1) ok = 1'b0;
        chk("one_lamp_per_road", {31'd0, ok}, 32'd1);
    endtask

    task automatic cyc(input logic r, input logic [3:0] d, input string name);
        rst    = r;
        demand = d;
        @(posedge clk);
        model_step(r, d);
        #1;
        model_check(name);
    endtask

    task automatic reset_seq();
        cyc(1'b1, 4'h0, "rst");
        cyc(1'b1, 4'h0, "rst");
        cyc(1'b0, 4'h0, "rel_allred");
        cyc(1'b0, 4'h0, "first_green");
        chk("first_green_road0", {28'd0, green}, 32'h1);
    endtask

    task automatic run_to_green(input logic [3:0] d, input int budget, output int road);
        int n;
        n = 0;
        do begin
            cyc(1'b0, d, "run_green");
            n++;
        end while (!(phase == 2'b01 && green_start) && n < budget);
        if (!(phase == 2'b01 && green_start)) chk("green_timeout", 32'd0, 32'd1);
        road = int'(active_road);
    endtask

    task automatic run_to_yellow(input logic [3:0] d, input int budget);
        int n;
        n = 0;
        do begin
            cyc(1'b0, d, "run_yellow");
            n++;
        end while (phase != 2'b10 && n < budget);
        if (phase != 2'b10) chk("yellow_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int road, n, c, n_gs, n_grn;
        logic       rr;
        logic [3:0] dd;
        rst    = 1'b1;
        demand = 4'h0;

        // Reset, first green on road 0, then gap-out to road 2 after minimum green.
        for (int i = 0; i < 3; i++) tbl[i] = '{1'b1, 4'h0, 4'hF, 4'h0, 4'h0, 2'd0, 2'd0, 1'b0};
        tbl[3] = '{1'b0, 4'h0, 4'hF, 4'h0, 4'h0, 2'd0, 2'd0, 1'b0};
        tbl[4] = '{1'b0, 4'h0, 4'hE, 4'h0, 4'h1, 2'd1, 2'd0, 1'b1};
        for (int i = 5; i < 8; i++)  tbl[i] = '{1'b0, 4'h4, 4'hE, 4'h0, 4'h1, 2'd1, 2'd0, 1'b0};
        for (int i = 8; i < 11; i++) tbl[i] = '{1'b0, 4'h4, 4'hE, 4'h1, 4'h0, 2'd2, 2'd0, 1'b0};
        tbl[11] = '{1'b0, 4'h4, 4'hF, 4'h0, 4'h0, 2'd0, 2'd0, 1'b0};
        tbl[12] = '{1'b0, 4'h4, 4'hF, 4'h0, 4'h0, 2'd0, 2'd0, 1'b0};
        tbl[13] = '{1'b0, 4'h4, 4'hB, 4'h0, 4'h4, 2'd1, 2'd2, 1'b1};
        tbl[14] = '{1'b0, 4'h4, 4'hB, 4'h0, 4'h4, 2'd1, 2'd2, 1'b0};
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].rst, tbl[i].dem, "tbl_model");
            chk($sformatf("tbl_row%0d", i),
                {15'd0, red, yellow, green, phase, active_road, green_start},
                {15'd0, tbl[i].red, tbl[i].yel, tbl[i].grn, tbl[i].ph, tbl[i].act, tbl[i].gs});
        end

        // Idle: no demand ever, road 0 rests green with a single green_start pulse.
        cyc(1'b1, 4'h0, "idle_rst");
        cyc(1'b1, 4'h0, "idle_rst");
        cyc(1'b1, 4'h0, "idle_rst");
        n_gs  = 0;
        n_grn = 0;
        for (int i = 0; i < 52; i++) begin
            cyc(1'b0, 4'h0, "idle");
            if (green_start) n_gs++;
            if (green == 4'b0001) n_grn++;
        end
        chk("idle_gs_pulses", n_gs, 1);
        chk("idle_green_cycles", n_grn, 51);

        // Max-out: road 0 stays busy while road 1 waits.
        reset_seq();
        n = 1;
        while (phase == 2'b01 && n < 40) begin
            cyc(1'b0, 4'b0011, "maxout");
            if (phase == 2'b01) n++;
        end
        chk("maxout_green_len", n, MAXG);
        c = 1;
        while (phase != 2'b01 && c < 40) begin
            cyc(1'b0, 4'b0011, "clearance");
            if (phase != 2'b01) c++;
        end
        chk("clearance_len", c, YT + ART);
        chk("maxout_next_road", {30'd0, active_road}, 32'd1);

        // Round-robin wrap from road 3 back to road 0, then on to road 1.
        run_to_green(4'b1000, 40, road);
        chk("reach_road3", road, 3);
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'b1011, "road3_busy");
        cyc(1'b0, 4'b0011, "road3_gap");
        chk("road3_gapout_yellow", {30'd0, phase}, 32'd2);
        run_to_green(4'b0011, 40, road);
        chk("wrap_to_road0", road, 0);
        run_to_green(4'b0011, 40, road);
        chk("rr_after_wrap", road, 1);

        // Late demand during yellow does not change the chosen road.
        reset_seq();
        run_to_yellow(4'b0100, 40);
        run_to_green(4'b0010, 40, road);
        chk("late_demand_ignored", road, 2);

        // Reset in the second cycle of road 1 yellow.
        run_to_yellow(4'b0010, 40);
        run_to_green(4'b0010, 40, road);
        chk("reach_road1", road, 1);
        run_to_yellow(4'b0001, 40);
        cyc(1'b0, 4'b0001, "yellow_cyc2");
        chk("yellow_road1", {28'd0, yellow}, 32'h2);
        cyc(1'b1, 4'b0001, "mid_rst");
        chk("mid_rst_phase", {30'd0, phase}, 32'd0);
        chk("mid_rst_red", {28'd0, red}, 32'hF);
        chk("mid_rst_active", {30'd0, active_road}, 32'd0);
        cyc(1'b0, 4'h0, "restart");
        cyc(1'b0, 4'h0, "restart");
        chk("restart_green0", {28'd0, green}, 32'h1);

        // Random demand with occasional resets.
        dd = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) dd = 4'($urandom_range(0, 15));
            rr = ($urandom_range(0, 399) == 0);
            cyc(rr, dd, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
